// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction-fetch front end. Keeps the fetch PC, issues one
// outstanding imem request at a time, buffers returned words with their PC in a
// DEPTH-entry circular queue and presents the head to decode over valid/ready.
// Branch redirects flush the queue and turn an in-flight request stale.
// Optional build macro FETCH_PERF_EN enables the saturating perf counters;
// without it the perf_* ports are tied to zero.
//
// state    | meaning
// S_IDLE   | no request outstanding; may issue, or stop at halt/error PC
// S_WAIT   | request outstanding; its response is pushed into the queue
// S_DROP   | stale request outstanding; its response is discarded
// S_HALTED | run finished; no more requests, queue still drains
module fetch_queue_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       DEPTH      = 4,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(32'h1000),
  parameter logic [ADDR_W-1:0] HALT_ADDR  = ADDR_W'(32'h9080),
  parameter logic [ADDR_W-1:0] ERR_ADDR   = ADDR_W'(32'h5040)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [1:0]        imem_status,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              halt,
  output logic              err,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed,
  output logic [31:0]       perf_stall
);

  localparam int unsigned      PTR_W   = $clog2(DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP, S_HALTED} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halt_q, halt_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic rsp_vld, redir, pop, push, issue;

  // Next-state, queue handshake and request decode.
  always_comb begin
    rsp_vld = (imem_status == 2'b10);
    redir   = redirect && (state_q != S_HALTED);
    pop     = (cnt_q != '0) && inst_ready && !redir;
    state_d = state_q;
    pc_d    = pc_q;
    halt_d  = halt_q;
    err_d   = err_q;
    push    = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (redir) begin
          pc_d = redirect_pc;
        end else if (pc_q == HALT_ADDR) begin
          state_d = S_HALTED;
          halt_d  = 1'b1;
        end else if (pc_q == ERR_ADDR) begin
          state_d = S_HALTED;
          halt_d  = 1'b1;
          err_d   = 1'b1;
        end else if ((cnt_q != DEPTH_C) || pop) begin
          // A slot is reserved for the word this request will return.
          issue   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redir) begin
          pc_d    = redirect_pc;
          state_d = rsp_vld ? S_IDLE : S_DROP;
        end else if (rsp_vld) begin
          push    = 1'b1;
          pc_d    = pc_q + ADDR_W'(4);
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (redir) pc_d = redirect_pc;
        // A redirect landing on the stale response still retires it.
        if (rsp_vld) state_d = S_IDLE;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req   = issue && !rst;
  assign imem_addr  = pc_q;
  assign inst_valid = (cnt_q != '0);
  assign inst_data  = q_data[rd_ptr_q];
  assign inst_pc    = q_pc[rd_ptr_q];
  assign halt       = halt_q;
  assign err        = err_q;

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= START_ADDR;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue outright.
  always_ff @(posedge clk) begin
    if (rst || redir) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Queue storage; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr_q] <= imem_rdata;
      q_pc[wr_ptr_q]   <= pc_q;
    end
  end

  // Occupancy can never exceed DEPTH because issue reserves the slot.
  always_ff @(posedge clk) begin
    if (!rst) assert (cnt_q <= DEPTH_C);
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, flushed_q, stall_q;
  logic [31:0] flush_amt;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Words lost to a redirect: queued entries plus the in-flight word, if any.
  always_comb begin
    flush_amt = 32'd0;
    if (redir) flush_amt = 32'(cnt_q) + ((state_q == S_WAIT) ? 32'd1 : 32'd0);
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= 32'd0;
      flushed_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      fetched_q <= sat_add(fetched_q, {31'd0, push});
      flushed_q <= sat_add(flushed_q, flush_amt);
      stall_q   <= sat_add(stall_q, {31'd0, inst_ready && !inst_valid});
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
  assign perf_stall   = stall_q;
`else
  assign perf_fetched = 32'h0;
  assign perf_flushed = 32'h0;
  assign perf_stall   = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: a transaction-level model (word queue, outstanding
// and stale flags) predicts every output each cycle; directed scenarios add
// hand-computed literal expectations.
module tb_fetch_queue_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] START = 32'h1000;
  localparam logic [31:0] HALTA = 32'h9080;
  localparam logic [31:0] ERRA  = 32'h5040;
`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [1:0]  imem_status = 2'b00;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        halt;
  logic        err;
  logic [31:0] perf_fetched, perf_flushed, perf_stall;

  always #5 clk = ~clk;

  fetch_queue_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_status(imem_status), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .halt(halt), .err(err),
    .perf_fetched(perf_fetched), .perf_flushed(perf_flushed), .perf_stall(perf_stall)
  );

  typedef struct packed {logic [31:0] pc; logic [31:0] data;} ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc = START;
  bit          m_busy, m_stale, m_halted, m_err, m_known;
  int unsigned m_fetched, m_flushed, m_stall;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          have_resp = 1'b0;
  int          resp_cyc;
  logic [31:0] resp_addr;
  logic [31:0] popped[$];
  int          req_cnt;
  int          first_req, first_valid;
  logic [31:0] first_addr;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pop_at(input int i);
    if (i < popped.size()) return popped[i];
    return 32'hFFFF_FFFF;
  endfunction

  // Model: a request goes out when nothing is outstanding, the PC is not a stop
  // address, and the returned word is guaranteed a queue slot.
  function automatic bit m_issue();
    return !rst && !redirect && !m_busy && !m_halted && m_pc != HALTA && m_pc != ERRA &&
           (m_q.size() < DEPTH || (m_q.size() > 0 && inst_ready));
  endfunction

  task automatic model_update();
    bit   rsp, pop;
    ent_t e;
    rsp = (imem_status == 2'b10);
    if (rst) begin
      m_q.delete();
      m_pc = START; m_busy = 0; m_stale = 0; m_halted = 0; m_err = 0;
      m_fetched = 0; m_flushed = 0; m_stall = 0; m_known = 1;
      return;
    end
    if (inst_ready && m_q.size() == 0) m_stall++;
    if (redirect && !m_halted) begin
      m_flushed += m_q.size() + ((m_busy && !m_stale) ? 1 : 0);
      m_q.delete();
      m_pc = redirect_pc;
      if (m_busy) begin
        if (rsp) begin m_busy = 0; m_stale = 0; end
        else m_stale = 1;
      end
    end else begin
      pop = (m_q.size() != 0) && inst_ready;
      if (m_issue()) m_busy = 1;
      else if (!m_busy && !m_halted && m_pc == HALTA) m_halted = 1;
      else if (!m_busy && !m_halted && m_pc == ERRA) begin m_halted = 1; m_err = 1; end
      else if (m_busy && rsp) begin
        if (!m_stale) begin
          e.pc = m_pc; e.data = imem_rdata;
          m_q.push_back(e);
          m_fetched++;
          m_pc = m_pc + 32'd4;
        end
        m_busy = 0; m_stale = 0;
      end
      if (pop) void'(m_q.pop_front());
    end
  endtask

  task automatic check_outputs();
    chk("imem_req", 32'(imem_req), 32'(m_issue()));
    if (imem_req && m_issue()) chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0 && inst_valid) begin
      chk("inst_pc", inst_pc, m_q[0].pc);
      chk("inst_data", inst_data, m_q[0].data);
    end
    chk("halt", 32'(halt), 32'(m_halted));
    chk("err", 32'(err), 32'(m_err));
    chk("perf_fetched", perf_fetched, PERF ? m_fetched : 32'd0);
    chk("perf_flushed", perf_flushed, PERF ? m_flushed : 32'd0);
    chk("perf_stall", perf_stall, PERF ? m_stall : 32'd0);
  endtask

  // One clock: compare on the falling edge, advance the model on the rising
  // edge, then drive the next cycle's imem response.
  task automatic cycle();
    @(negedge clk);
    if (m_known) check_outputs();
    if (imem_req) begin
      have_resp = 1'b1; resp_cyc = cyc + lat; resp_addr = imem_addr; req_cnt++;
      if (first_req < 0) begin first_req = cyc; first_addr = imem_addr; end
    end
    if (inst_valid && first_valid < 0) first_valid = cyc;
    if (inst_valid && inst_ready && !redirect && !rst) popped.push_back(inst_pc);
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    redirect = 1'b0;
    rst = 1'b0;
    if (have_resp && resp_cyc == cyc) begin
      imem_status = 2'b10; imem_rdata = word_of(resp_addr); have_resp = 1'b0;
    end else begin
      imem_status = cyc[0] ? 2'b01 : 2'b11;
      imem_rdata = 32'hBAD0_0000 | 32'(cyc);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_obs();
    popped.delete(); req_cnt = 0; first_req = -1; first_valid = -1; first_addr = 32'hFFFF_FFFF;
  endtask

  task automatic do_reset();
    rst = 1'b1; cycle();
    rst = 1'b1; cycle();
    clear_obs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear_obs();
    // 1: straight-line fetch with 1-cycle memory
    lat = 1; inst_ready = 1'b0;
    do_reset();
    chk("t1_rst_valid", 32'(inst_valid), 32'd0);
    chk("t1_rst_halt", 32'(halt), 32'd0);
    chk("t1_rst_fetched", perf_fetched, 32'd0);
    inst_ready = 1'b1;
    run(10);
    chk("t1_latency", 32'(first_valid - first_req), 32'd2);
    chk("t1_first_addr", first_addr, 32'h1000);
    chk("t1_pc0", pop_at(0), 32'h1000);
    chk("t1_pc1", pop_at(1), 32'h1004);
    chk("t1_pc2", pop_at(2), 32'h1008);

    // 2: back-pressure fills exactly DEPTH, then drains without a gap
    inst_ready = 1'b0;
    do_reset();
    run(20);
    chk("t2_model_depth", 32'(m_q.size()), 32'd4);
    chk("t2_req_cnt", 32'(req_cnt), 32'd4);
    chk("t2_valid", 32'(inst_valid), 32'd1);
    popped.delete();
    inst_ready = 1'b1;
    run(4);
    chk("t2_drain_cnt", 32'(popped.size()), 32'd4);
    chk("t2_pc0", pop_at(0), 32'h1000);
    chk("t2_pc1", pop_at(1), 32'h1004);
    chk("t2_pc2", pop_at(2), 32'h1008);
    chk("t2_pc3", pop_at(3), 32'h100C);

    // 3: redirect while waiting on a slow response
    lat = 3; inst_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 60 && !(m_busy && !m_stale && m_q.size() == 2 && imem_status != 2'b10); i++)
      cycle();
    chk("t3_setup", 32'(m_busy && !m_stale && m_q.size() == 2), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h2000;
    cycle();
    chk("t3_flushed", perf_flushed, PERF ? 32'd3 : 32'd0);
    popped.delete();
    inst_ready = 1'b1;
    for (int i = 0; i < 40 && popped.size() == 0; i++) cycle();
    chk("t3_next_pc", pop_at(0), 32'h2000);

    // 4: redirect in the same cycle a response lands, two entries queued
    lat = 1; inst_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 60 && !(imem_status == 2'b10 && m_busy && !m_stale && m_q.size() == 2); i++)
      cycle();
    chk("t4_setup", 32'(imem_status == 2'b10 && m_q.size() == 2), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h3000;
    cycle();
    chk("t4_empty", 32'(inst_valid), 32'd0);
    chk("t4_flushed", perf_flushed, PERF ? 32'd3 : 32'd0);
    popped.delete();
    inst_ready = 1'b1;
    for (int i = 0; i < 40 && popped.size() == 0; i++) cycle();
    chk("t4_next_pc", pop_at(0), 32'h3000);

    // 5: halt and error addresses, sticky until reset
    lat = 1; inst_ready = 1'b1;
    do_reset();
    run(3);
    redirect = 1'b1; redirect_pc = HALTA;
    req_cnt = 0;
    cycle();
    run(12);
    chk("t5_halt", 32'(halt), 32'd1);
    chk("t5_noerr", 32'(err), 32'd0);
    chk("t5_noreq", 32'(req_cnt), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h1000;
    cycle();
    run(5);
    chk("t5_halt_hold", 32'(halt), 32'd1);
    chk("t5_noreq2", 32'(req_cnt), 32'd0);
    do_reset();
    chk("t5_rst_halt", 32'(halt), 32'd0);
    redirect = 1'b1; redirect_pc = ERRA;
    cycle();
    run(8);
    chk("t5_err_halt", 32'(halt), 32'd1);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_err_noreq", 32'(req_cnt), 32'd0);
    run(10);
    chk("t5_err_hold", 32'(err), 32'd1);

    // 6: reset while waiting, stale response arrives right after
    lat = 2; inst_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 60 && !(m_busy && !m_stale && m_pc != START && have_resp && resp_cyc == cyc + 1); i++)
      cycle();
    chk("t6_setup", 32'(m_busy && m_pc != START), 32'd1);
    rst = 1'b1;
    cycle();
    clear_obs();
    chk("t6_valid", 32'(inst_valid), 32'd0);
    chk("t6_stale_rsp", 32'(imem_status), 32'd2);
    for (int i = 0; i < 20 && popped.size() == 0; i++) cycle();
    chk("t6_first_addr", first_addr, 32'h1000);
    chk("t6_next_pc", pop_at(0), 32'h1000);
    chk("t6_perf_fetched", perf_fetched, PERF ? m_fetched : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
